// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for the 5-stage pipeline.
//   - Flushes the IF/ID and ID/EX wrong-path instructions on a taken EX redirect.
//   - Freezes the whole pipeline while a push/pop spends STACK_LAT cycles in EX.
//   - Inserts RAW bubbles (load-use only when forwarding exists).
//   - Keeps a saturating count of cycles with pc_en low.
// Build option: define HAZARD_FORWARD_EN when the EX/MEM forwarding paths exist.
//   Only an EX load then stalls, and the mem_* inputs are unused.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_src1/2, *_used    ID source registers and their use flags
//   ex_*                 EX valid, destination, write/load/stack/redirect control
//   mem_*                MEM valid, destination, write enable
//   pc_en, pr1_*, pr2_*  PC and IF/ID, ID/EX enable/flush (combinational)
//   pr3_flush            EX/MEM bubble insert (combinational)
//   stall_cnt            saturating count of frozen-PC cycles (registered)
//   stk_busy             FSM is in STK_STALL (registered)
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned STACK_LAT  = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  ex_RF_write_en,
  input  logic                  ex_MEM_read,
  input  logic                  ex_is_stack,
  input  logic                  ex_pc_redirect,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  mem_RF_write_en,
  output logic                  pc_en,
  output logic                  pr1_en,
  output logic                  pr1_flush,
  output logic                  pr2_en,
  output logic                  pr2_flush,
  output logic                  pr3_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  stk_busy
);

  localparam int unsigned STK_CNT_W = 4;
  // The entry cycle is the first freeze, so the down-counter starts at LAT-2.
  localparam logic [STK_CNT_W-1:0] STK_CNT_INIT =
    (STACK_LAT > 1) ? STK_CNT_W'(STACK_LAT - 2) : STK_CNT_W'(0);
  localparam bit STK_STALL_EN = (STACK_LAT > 1);

  typedef enum logic {
    RUN,
    STK_STALL
  } state_e;

  state_e               state_q, state_d;
  logic [STK_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic ex_hit_en;
  logic mem_hit_en;
  logic hazard;
  logic redirect;
  logic unused_ok;

  // Which pipeline writers can create a RAW hazard in this build.
`ifdef HAZARD_FORWARD_EN
  assign ex_hit_en  = ex_valid & ex_RF_write_en & ex_MEM_read;
  assign mem_hit_en = 1'b0;
  assign unused_ok  = ^{mem_valid, mem_dst, mem_RF_write_en};
`else
  assign ex_hit_en  = ex_valid & ex_RF_write_en;
  assign mem_hit_en = mem_valid & mem_RF_write_en;
  assign unused_ok  = ex_MEM_read;
`endif

  // RAW detection against the used ID sources.
  assign hazard =
    (id_src1_used & ((ex_hit_en  & (ex_dst  == id_src1)) |
                     (mem_hit_en & (mem_dst == id_src1)))) |
    (id_src2_used & ((ex_hit_en  & (ex_dst  == id_src2)) |
                     (mem_hit_en & (mem_dst == id_src2))));

  assign redirect = ex_valid & ex_pc_redirect;

  // Next-state and enable/flush decode.
  always_comb begin
    pc_en     = 1'b1;
    pr1_en    = 1'b1;
    pr2_en    = 1'b1;
    pr1_flush = 1'b0;
    pr2_flush = 1'b0;
    pr3_flush = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;

    if (rst) begin
      pc_en     = 1'b0;
      pr1_flush = 1'b1;
      pr2_flush = 1'b1;
      pr3_flush = 1'b1;
      state_d   = RUN;
      cnt_d     = '0;
    end else if ((state_q == STK_STALL) && (cnt_q != '0)) begin
      // Mid-stall: hold everything, ignore redirect and hazards.
      pc_en     = 1'b0;
      pr1_en    = 1'b0;
      pr2_en    = 1'b0;
      pr3_flush = 1'b1;
      cnt_d     = cnt_q - STK_CNT_W'(1);
    end else begin
      // RUN, or the STK_STALL release cycle (stack entry suppressed there).
      if (state_q == STK_STALL) begin
        state_d = RUN;
      end
      if (redirect) begin
        pr1_flush = 1'b1;
        pr2_flush = 1'b1;
      end else if ((state_q == RUN) && ex_valid && ex_is_stack && STK_STALL_EN) begin
        pc_en     = 1'b0;
        pr1_en    = 1'b0;
        pr2_en    = 1'b0;
        pr3_flush = 1'b1;
        state_d   = STK_STALL;
        cnt_d     = STK_CNT_INIT;
      end else if (hazard) begin
        pc_en     = 1'b0;
        pr1_en    = 1'b0;
        pr2_flush = 1'b1;
      end
    end
  end

  // Saturating stall counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign stk_busy  = (state_q == STK_STALL);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl.
// Two instances share stimulus: dut_a (STACK_LAT=4, CNT_W=16) and
// dut_b (STACK_LAT=3, CNT_W=2, so its stall counter saturates).
// Each DUT has its own ex_is_stack input so stack sequences can be aimed at one.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW = 3;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Output vector: {pc_en, pr1_en, pr1_flush, pr2_en, pr2_flush, pr3_flush, stk_busy}
  localparam logic [6:0] NORM  = 7'b1101000;
  localparam logic [6:0] BUB   = 7'b0001100;
  localparam logic [6:0] FLSH  = 7'b1111100;
  localparam logic [6:0] FRZ   = 7'b0000010;
  localparam logic [6:0] FRZB  = 7'b0000011;
  localparam logic [6:0] REL   = 7'b1101001;
  localparam logic [6:0] RELF  = 7'b1111101;
  localparam logic [6:0] RSTV  = 7'b0111110;
  localparam logic [6:0] RSTVB = 7'b0111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_src1, id_src2, ex_dst, mem_dst;
  logic          id_src1_used, id_src2_used;
  logic          ex_valid, ex_RF_write_en, ex_MEM_read, ex_pc_redirect;
  logic          stk_a, stk_b;
  logic          mem_valid, mem_RF_write_en;

  logic          pc_en_a, pr1_en_a, pr1_flush_a, pr2_en_a, pr2_flush_a, pr3_flush_a, stk_busy_a;
  logic          pc_en_b, pr1_en_b, pr1_flush_b, pr2_en_b, pr2_flush_b, pr3_flush_b, stk_busy_b;
  logic [15:0]   stall_cnt_a;
  logic [1:0]    stall_cnt_b;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .STACK_LAT(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_RF_write_en(ex_RF_write_en),
    .ex_MEM_read(ex_MEM_read), .ex_is_stack(stk_a), .ex_pc_redirect(ex_pc_redirect),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_RF_write_en(mem_RF_write_en),
    .pc_en(pc_en_a), .pr1_en(pr1_en_a), .pr1_flush(pr1_flush_a),
    .pr2_en(pr2_en_a), .pr2_flush(pr2_flush_a), .pr3_flush(pr3_flush_a),
    .stall_cnt(stall_cnt_a), .stk_busy(stk_busy_a)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .STACK_LAT(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_RF_write_en(ex_RF_write_en),
    .ex_MEM_read(ex_MEM_read), .ex_is_stack(stk_b), .ex_pc_redirect(ex_pc_redirect),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_RF_write_en(mem_RF_write_en),
    .pc_en(pc_en_b), .pr1_en(pr1_en_b), .pr1_flush(pr1_flush_b),
    .pr2_en(pr2_en_b), .pr2_flush(pr2_flush_b), .pr3_flush(pr3_flush_b),
    .stall_cnt(stall_cnt_b), .stk_busy(stk_busy_b)
  );

  typedef struct packed {
    logic [6:0]  out_a;
    logic [6:0]  out_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_cnt_a = '0;
  logic [1:0]  exp_cnt_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Push this cycle's expectation, compare at negedge, then advance the stall trackers.
  task automatic step(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    exp_t e;
    e.out_a = ea;
    e.out_b = eb;
    e.cnt_a = exp_cnt_a;
    e.cnt_b = exp_cnt_b;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, "/queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "/a_out"}, 32'({pc_en_a, pr1_en_a, pr1_flush_a, pr2_en_a, pr2_flush_a,
                                  pr3_flush_a, stk_busy_a}), 32'(e.out_a));
      check({tag, "/b_out"}, 32'({pc_en_b, pr1_en_b, pr1_flush_b, pr2_en_b, pr2_flush_b,
                                  pr3_flush_b, stk_busy_b}), 32'(e.out_b));
      check({tag, "/a_cnt"}, 32'(stall_cnt_a), 32'(e.cnt_a));
      check({tag, "/b_cnt"}, 32'(stall_cnt_b), 32'(e.cnt_b));
    end
    @(posedge clk);
    if (rst) begin
      exp_cnt_a = '0;
      exp_cnt_b = '0;
    end else begin
      if (!ea[6] && exp_cnt_a != 16'hFFFF) exp_cnt_a = exp_cnt_a + 16'd1;
      if (!eb[6] && exp_cnt_b != 2'b11)    exp_cnt_b = exp_cnt_b + 2'd1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    id_src1 = '0; id_src2 = '0; id_src1_used = 1'b0; id_src2_used = 1'b0;
    ex_valid = 1'b0; ex_dst = '0; ex_RF_write_en = 1'b0; ex_MEM_read = 1'b0;
    ex_pc_redirect = 1'b0; stk_a = 1'b0; stk_b = 1'b0;
    mem_valid = 1'b0; mem_dst = '0; mem_RF_write_en = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step("reset0", RSTV, RSTV);
    step("reset1", RSTV, RSTV);
    idle();
    step("idle", NORM, NORM);

    // Load to r3 in EX, ID reads r3 on src1; the load then moves to MEM.
    idle();
    ex_valid = 1'b1; ex_dst = 3'd3; ex_RF_write_en = 1'b1; ex_MEM_read = 1'b1;
    id_src1 = 3'd3; id_src1_used = 1'b1;
    step("ldu_ex", BUB, BUB);
    ex_valid = 1'b0; mem_valid = 1'b1; mem_dst = 3'd3; mem_RF_write_en = 1'b1;
    step("ldu_mem", FWD ? NORM : BUB, FWD ? NORM : BUB);
    idle();
    step("ldu_done", NORM, NORM);

    // ALU write to r2, ID reads r2 on src2.
    ex_valid = 1'b1; ex_dst = 3'd2; ex_RF_write_en = 1'b1;
    id_src2 = 3'd2; id_src2_used = 1'b1;
    step("alu_ex", FWD ? NORM : BUB, FWD ? NORM : BUB);
    ex_valid = 1'b0; mem_valid = 1'b1; mem_dst = 3'd2; mem_RF_write_en = 1'b1;
    step("alu_mem", FWD ? NORM : BUB, FWD ? NORM : BUB);
    idle();
    step("alu_done", NORM, NORM);

    // Matching source that is not used, and a matching dst on bubbles.
    ex_valid = 1'b1; ex_dst = 3'd5; ex_RF_write_en = 1'b1; ex_MEM_read = 1'b1;
    id_src1 = 3'd5; id_src1_used = 1'b0; id_src2 = 3'd1; id_src2_used = 1'b1;
    step("unused_src", NORM, NORM);
    ex_valid = 1'b0; id_src1_used = 1'b1;
    mem_valid = 1'b0; mem_dst = 3'd5; mem_RF_write_en = 1'b1;
    step("bubble_dst", NORM, NORM);

    // Redirect plus load-use in RUN: flush only, no stall counted.
    idle();
    ex_valid = 1'b1; ex_pc_redirect = 1'b1; ex_dst = 3'd4; ex_RF_write_en = 1'b1;
    ex_MEM_read = 1'b1; id_src1 = 3'd4; id_src1_used = 1'b1;
    step("redir_haz", FLSH, FLSH);
    idle();
    step("redir_done", NORM, NORM);

    // Push on dut_a (STACK_LAT=4): three freezes then release.
    ex_valid = 1'b1; stk_a = 1'b1;
    step("push_c0", FRZ, NORM);
    step("push_c1", FRZB, NORM);
    step("push_c2", FRZB, NORM);
    step("push_rel", REL, NORM);
    idle();
    step("push_done", NORM, NORM);

    // Pop on dut_b (STACK_LAT=3); return redirect resolves while frozen.
    ex_valid = 1'b1; stk_b = 1'b1;
    step("pop_c0", NORM, FRZ);
    ex_pc_redirect = 1'b1;
    step("pop_c1", FLSH, FRZB);
    step("pop_rel", FLSH, RELF);
    idle();
    step("pop_done", NORM, NORM);

    // Reset on the second STK_STALL cycle of dut_a aborts the stall.
    ex_valid = 1'b1; stk_a = 1'b1;
    step("rstk_c0", FRZ, NORM);
    step("rstk_c1", FRZB, NORM);
    rst = 1'b1;
    step("rstk_rst", RSTVB, RSTV);
    idle();
    step("rstk_after", NORM, NORM);
    step("rstk_idle", NORM, NORM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline. It watches the ID and EX stage control fields (register file write enable, memory read, stack push/pop, PC redirect) and drives the enable and flush inputs of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It inserts load-use bubbles, flushes wrong-path instructions on a taken redirect, and freezes the pipeline while a multi-cycle stack operation occupies EX. It also keeps a saturating stall-cycle counter.

## Interface
- Clocking: one clock; reset is synchronous and active-high (`clk`, `rst`).

Parameters:
- `REG_ADDR_W`, 3: register-file address width.
- `STACK_LAT`, 2: number of cycles a push/pop stays in EX; legal range 1..16.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `id_src1`, `id_src2` in REG_ADDR_W: source registers of the ID instruction.
- `id_src1_used`, `id_src2_used` in 1: the ID instruction actually reads that source.
- `ex_valid` in 1: EX holds a real instruction, not a bubble.
- `ex_dst` in REG_ADDR_W: EX destination register.
- `ex_RF_write_en`, `ex_MEM_read` in 1: EX control bits.
- `ex_is_stack` in 1: EX instruction is a push or a pop.
- `ex_pc_redirect` in 1: EX resolved a taken branch, jump or stack return.
- `mem_valid` in 1: MEM holds a real instruction.
- `mem_dst` in REG_ADDR_W: MEM destination register.
- `mem_RF_write_en` in 1: MEM control bit.
- `pc_en` out 1: PC update enable.
- `pr1_en`, `pr1_flush` out 1: IF/ID enable and flush.
- `pr2_en`, `pr2_flush` out 1: ID/EX enable and flush. Flush loads a bubble.
- `pr3_flush` out 1: EX/MEM bubble insert.
- `stall_cnt` out CNT_W: count of cycles with `pc_en`=0.
- `stk_busy` out 1: the FSM is in STK_STALL.

## Operation
- Two-state FSM: RUN and STK_STALL. A down-counter `cnt` (4 bits) supports it.
- All enable and flush outputs are combinational from the state, `cnt` and the inputs.
- Default outputs: all enables = 1, all flushes = 0.

Decision order in RUN and on the STK_STALL release cycle, highest priority first:
1. Redirect, when `ex_valid` & `ex_pc_redirect`: `pr1_flush`=1, `pr2_flush`=1, `pc_en`=1. This kills the IF and ID wrong-path instructions.
2. Stack entry, in RUN only, when `ex_valid` & `ex_is_stack` & STACK_LAT>1: freeze.
   - Freeze means `pc_en`=`pr1_en`=`pr2_en`=0 and `pr3_flush`=1.
   - Next state STK_STALL, with `cnt` <= STACK_LAT-2.
3. RAW hazard: freeze the front end (`pc_en`=`pr1_en`=0) and set `pr2_flush`=1. A hazard exists when a used ID source equals a matching destination.
   - EX match: `ex_valid` & `ex_RF_write_en` & (`ex_dst` == used source). This counts only when `ex_MEM_read` is set in forwarding builds.
   - MEM match: `mem_valid` & `mem_RF_write_en` & (`mem_dst` == used source). This applies in non-forwarding builds only.

STK_STALL behaviour:
- `cnt`≠0: freeze and decrement `cnt`. The redirect and hazard inputs are ignored.
- `cnt`=0 (release cycle): apply rules 1 and 3 only, then return to RUN. Stack entry is suppressed, so the same stack op does not retrigger.
- Net effect: a stack op stays in EX for exactly STACK_LAT cycles.

Reset and counter rules:
- While `rst`=1: outputs are `pc_en`=0, `pr1_en`=`pr2_en`=1, and `pr1_flush`=`pr2_flush`=`pr3_flush`=1.
- The next state is RUN with `cnt`=0, `stall_cnt`=0 and `stk_busy`=0.
- A reset during STK_STALL aborts the stall immediately.
- `stall_cnt` increments on each non-reset cycle with `pc_en`=0. It saturates at all-ones and does not wrap.

## Timing
- Redirect flush, bubble insert and freeze all act in the same cycle the condition is present. They take effect at that cycle's `clk` edge.
- A load-use hazard costs exactly 1 bubble with forwarding enabled. Without forwarding, a RAW hazard costs up to 2 bubbles: one for the EX match, one for the MEM match.
- Stack op: STACK_LAT-1 freeze cycles. `stk_busy` is high for STACK_LAT-2 cycles plus the release cycle, and is low for STACK_LAT ≤ 1.
- STACK_LAT=1: stack ops never stall and STK_STALL is unreachable.
- Redirect and hazard in the same cycle: the redirect wins and no bubble counts. `stall_cnt` is unchanged because `pc_en`=1.

## Configuration
- `HAZARD_FORWARD_EN` defined: EX/MEM forwarding is assumed to exist. Only an EX load (`ex_MEM_read`=1) triggers a RAW stall, and the `mem_*` inputs are unused.
- Not defined: any valid EX or MEM writer whose destination matches a used source triggers a stall.

## Test plan
- Forwarding on; EX is a load to r3 and ID reads r3 on src1. Required: one cycle of `pc_en`=0, `pr1_en`=0, `pr2_flush`=1, then normal flow; `stall_cnt`=1.
- Forwarding off; EX is an ALU write to r2 and ID reads r2 on src2. Required: 2 stall cycles (EX match, then MEM match); `stall_cnt`=2.
- STACK_LAT=4; push enters EX. Required: 3 freeze cycles with `pr3_flush`=1 and `stk_busy` high for 3 cycles; `stall_cnt`=3.
- STACK_LAT=3; pop with `ex_pc_redirect`=1 enters EX. Required: a freeze cycle that ignores the redirect, then the release cycle asserts `pr1_flush`=`pr2_flush`=1 with `pc_en`=1.
- Redirect together with a load-use match in RUN. Required: the flush only, `pc_en`=1, `stall_cnt` unchanged.
- `rst` asserted on the second STK_STALL cycle. Required: during reset all flushes =1 and `pc_en`=0; next cycle the FSM is in RUN with `stk_busy`=0 and `stall_cnt`=0.
